// File: rtl/noc_input_buffer.sv
// Per-input-port flit FIFO feeding the switch allocator and crossbar.
// Each entry holds {target, data}. The head entry's target goes to the allocator.
// A grant equal to that target pops the head, and pop_ctrl reports the pop back
// to the allocator.
//
// Handshake:
//   - Upstream push: a flit is taken when in_valid & in_ready & (in_targ != 0).
//     in_ready depends only on occupancy, so a pop in the same cycle never raises
//     in_ready.
//   - Downstream pop: the head is consumed when the buffer is not empty and
//     grant == head_targ (grant != 0).
module noc_input_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_targ,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [2:0]        grant,
    output logic [2:0]        head_targ,
    output logic [DATA_W-1:0] out_data,
    output logic              pop_ctrl,
    output logic [PTR_W:0]    occupancy,
    output logic              overflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [2:0]        targ_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              push;
    logic              bad_push;

    // Handshake qualifiers and head presentation, gated to zero while empty
    always_comb begin
        empty     = (occupancy == '0);
        in_ready  = (occupancy != FULL_CNT);
        push      = in_valid & in_ready & (in_targ != 3'd0);
        bad_push  = in_valid & (~in_ready | (in_targ == 3'd0));
        head_targ = empty ? 3'd0 : targ_mem[rd_ptr];
        out_data  = empty ? '0 : data_mem[rd_ptr];
        pop_ctrl  = ~empty & (grant != 3'd0) & (grant == head_targ);
    end

    // Flit storage; the contents need no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            targ_mem[wr_ptr] <= in_targ;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and sticky overflow; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ctrl)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop_ctrl)
                occupancy <= occupancy + 1'b1;
            else if (pop_ctrl && !push)
                occupancy <= occupancy - 1'b1;
            if (bad_push)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed and randomized bench for noc_input_buffer. The reference is a pair of
// queues plus a sticky flag.
module tb_noc_input_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [2:0]        in_targ;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [2:0]        grant;
    logic [2:0]        head_targ;
    logic [DATA_W-1:0] out_data;
    logic              pop_ctrl;
    logic [PTR_W:0]    occupancy;
    logic              overflow;

    noc_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_targ   (in_targ),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .grant     (grant),
        .head_targ (head_targ),
        .out_data  (out_data),
        .pop_ctrl  (pop_ctrl),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [2:0]        targ_q [$];
    logic [DATA_W-1:0] exp_q  [$];
    logic              model_ovf;
    int                vectors;
    int                miscompares;
    int                pops_seen;
    int                pops_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the model's current contents
    task automatic check_state(input logic [2:0] g, output logic exp_pop);
        logic [2:0] exp_head;
        exp_head = (targ_q.size() == 0) ? 3'd0 : targ_q[0];
        exp_pop  = (targ_q.size() != 0) && (g != 3'd0) && (g == exp_head);
        chk("head_targ", 32'(head_targ), 32'(exp_head));
        chk("occupancy", 32'(occupancy), 32'(targ_q.size()));
        chk("in_ready", 32'(in_ready), 32'(targ_q.size() != DEPTH));
        chk("overflow", 32'(overflow), 32'(model_ovf));
        chk("pop_ctrl", 32'(pop_ctrl), 32'(exp_pop));
        if (exp_q.size() != 0)
            chk("out_data", out_data, exp_q[0]);
    endtask

    // Drive one cycle of inputs, check before the edge, then advance the model
    task automatic step(input logic v, input logic [2:0] t, input logic [31:0] d, input logic [2:0] g);
        logic exp_pop;
        logic exp_push;
        @(negedge clk);
        in_valid = v;
        in_targ  = t;
        in_data  = d;
        grant    = g;
        #1;
        check_state(g, exp_pop);
        if (pop_ctrl === 1'b1)
            pops_seen++;
        exp_push = v && (targ_q.size() < DEPTH) && (t != 3'd0);
        if (v && ((targ_q.size() == DEPTH) || (t == 3'd0)))
            model_ovf = 1'b1;
        @(posedge clk);
        if (exp_pop) begin
            void'(targ_q.pop_front());
            void'(exp_q.pop_front());
            pops_model++;
        end
        if (exp_push) begin
            targ_q.push_back(t);
            exp_q.push_back(d);
        end
    endtask

    // Assert reset in the middle of a cycle and check that it takes effect at once
    task automatic mid_reset();
        @(negedge clk);
        in_valid = 1'b0;
        grant    = 3'd0;
        #2;
        rst = 1'b0;
        #1;
        targ_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        chk("rst_head", 32'(head_targ), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_pop", 32'(pop_ctrl), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [2:0] head_or_zero();
        return (targ_q.size() == 0) ? 3'd0 : targ_q[0];
    endfunction

    // Directed steps followed by randomized traffic
    initial begin
        logic [2:0] t;
        logic [2:0] g;
        vectors     = 0;
        miscompares = 0;
        pops_seen   = 0;
        pops_model  = 0;
        model_ovf   = 1'b0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_targ     = 3'd0;
        in_data     = '0;
        grant       = 3'd0;
        #12;
        rst = 1'b1;
        mid_reset();

        // 1: single push, visible after the edge, no bypass
        step(1'b1, 3'd3, 32'hA5A5_0001, 3'd0);
        step(1'b0, 3'd0, 32'd0, 3'd0);

        // 2: fill to full, then overflow on a fifth push; the head must not change
        mid_reset();
        step(1'b1, 3'd2, 32'h1111_0002, 3'd0);
        step(1'b1, 3'd5, 32'h1111_0005, 3'd0);
        step(1'b1, 3'd7, 32'h1111_0007, 3'd0);
        step(1'b1, 3'd1, 32'h1111_0001, 3'd0);
        step(1'b1, 3'd6, 32'hDEAD_BEEF, 3'd0);
        step(1'b1, 3'd4, 32'hDEAD_0004, 3'd2);
        step(1'b0, 3'd0, 32'd0, 3'd0);

        // 3: holding {2,5}; grant 2 pops once, and a repeated grant 2 is stale
        mid_reset();
        step(1'b1, 3'd2, 32'h2222_0002, 3'd0);
        step(1'b1, 3'd5, 32'h2222_0005, 3'd0);
        step(1'b0, 3'd0, 32'd0, 3'd2);
        step(1'b0, 3'd0, 32'd0, 3'd2);

        // 4: simultaneous push and pop at occupancy 2, then drain
        step(1'b1, 3'd6, 32'h3333_0006, 3'd0);
        step(1'b1, 3'd4, 32'h3333_0004, head_or_zero());
        step(1'b0, 3'd0, 32'd0, head_or_zero());
        step(1'b0, 3'd0, 32'd0, head_or_zero());
        step(1'b0, 3'd0, 32'd0, 3'd3);
        step(1'b1, 3'd0, 32'h0BAD_0000, 3'd0);
        step(1'b0, 3'd0, 32'd0, 3'd0);

        // 5: three full wraps of the pointers, targets cycling 1..7
        mid_reset();
        pops_seen = 0;
        for (int i = 0; i < 12; i++)
            step(1'b1, 3'((i % 7) + 1), $urandom, head_or_zero());
        step(1'b0, 3'd0, 32'd0, head_or_zero());
        step(1'b0, 3'd0, 32'd0, 3'd0);
        chk("wrap_pops", 32'(pops_seen), 32'd12);

        // Randomized traffic with a mix of matching, stale and absent grants
        mid_reset();
        pops_seen  = 0;
        pops_model = 0;
        for (int i = 0; i < 300; i++) begin
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                t = 3'd0;
            else if (t == 3'd0)
                t = 3'd1;
            g = ($urandom_range(0, 2) == 0) ? head_or_zero() : 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), t, $urandom, g);
        end
        chk("rand_pops", 32'(pops_seen), 32'(pops_model));

        // 6: reset at occupancy 3, then a grant after release must not pop
        mid_reset();
        step(1'b1, 3'd4, 32'h6666_0004, 3'd0);
        step(1'b1, 3'd5, 32'h6666_0005, 3'd0);
        step(1'b1, 3'd6, 32'h6666_0006, 3'd0);
        step(1'b0, 3'd0, 32'd0, 3'd0);
        mid_reset();
        step(1'b0, 3'd0, 32'd0, 3'd4);
        step(1'b0, 3'd0, 32'd0, 3'd0);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
